// File: rtl/ram_mp.sv
// ram_mp: multi-port byte-enabled RAM that clears every word after reset before accepting accesses.
// Optional write-first forwarding is built when RAM_MP_BYPASS_EN is defined; otherwise reads are read-first.
module ram_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2,
    parameter bit OUT_REG  = 1'b1,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [WR_PORTS-1:0]                wr_en_i,
    input  logic [WR_PORTS-1:0][AW-1:0]        wr_addr_i,
    input  logic [WR_PORTS-1:0][WIDTH-1:0]     wr_data_i,
    input  logic [WR_PORTS-1:0][NB-1:0]        wr_byte_en_i,
    input  logic [RD_PORTS-1:0]                rd_en_i,
    input  logic [RD_PORTS-1:0][AW-1:0]        rd_addr_i,
    output logic [RD_PORTS-1:0][WIDTH-1:0]     rd_data_o,
    output logic [RD_PORTS-1:0]                rd_valid_o,
    output logic                               ready_o,
    output logic                               wr_collision_o
);

    // Handshake: no backpressure. ready_o is a level that rises once the clear is done and stays
    // high until reset; a wr_en_i/rd_en_i strobe is accepted on any rising edge where ready_o is high.
    typedef enum logic {INIT, READY} state_t;

    state_t                          state;
    logic [AW-1:0]                   clr_cnt;
    logic [WIDTH-1:0]                mem [DEPTH];
    logic [WR_PORTS-1:0]             wr_hit;
    logic                            collision;
    logic [RD_PORTS-1:0][WIDTH-1:0]  rd_word;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // ready_o is the registered image of state == READY and doubles as the state observation point.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= INIT;
            clr_cnt <= '0;
            ready_o <= 1'b0;
        end else if (state == INIT) begin
            if (clr_cnt == AW'(DEPTH - 1)) begin
                state   <= READY;
                ready_o <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < WR_PORTS; p++) begin
            wr_hit[p] = wr_en_i[p] & ready_o & in_range(wr_addr_i[p]);
        end
    end

    // Ports are applied highest index first so the lowest-index port's bytes land last and win.
    always_ff @(posedge clk_i) begin
        if (!ready_o) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int p = WR_PORTS - 1; p >= 0; p--) begin
                if (wr_hit[p]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_byte_en_i[p][b]) begin
                            mem[wr_addr_i[p]][8*b +: 8] <= wr_data_i[p][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        collision = 1'b0;
        for (int p = 0; p < WR_PORTS; p++) begin
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (wr_hit[p] && wr_hit[q] && (wr_addr_i[p] == wr_addr_i[q]) &&
                    |(wr_byte_en_i[p] & wr_byte_en_i[q])) begin
                    collision = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_collision_o <= 1'b0;
        end else begin
            wr_collision_o <= collision;
        end
    end

    always_comb begin
        for (int r = 0; r < RD_PORTS; r++) begin
            rd_word[r] = in_range(rd_addr_i[r]) ? mem[rd_addr_i[r]] : '0;
`ifdef RAM_MP_BYPASS_EN
            for (int p = WR_PORTS - 1; p >= 0; p--) begin
                if (wr_hit[p] && (wr_addr_i[p] == rd_addr_i[r])) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_byte_en_i[p][b]) begin
                            rd_word[r][8*b +: 8] = wr_data_i[p][8*b +: 8];
                        end
                    end
                end
            end
`endif
        end
    end

    if (OUT_REG) begin : g_out_reg
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rd_data_o  <= '0;
                rd_valid_o <= '0;
            end else begin
                for (int r = 0; r < RD_PORTS; r++) begin
                    rd_valid_o[r] <= rd_en_i[r] & ready_o;
                    if (rd_en_i[r] && ready_o) begin
                        rd_data_o[r] <= rd_word[r];
                    end
                end
            end
        end
    end else begin : g_out_comb
        always_comb begin
            rd_valid_o = rd_en_i & {RD_PORTS{ready_o}};
            rd_data_o  = ready_o ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_ram_mp.sv
// tb_ram_mp: directed table-driven bench for ram_mp; a registered 2W/2R instance and a combinational 4W/4R instance.
// Read-during-write expectation follows RAM_MP_BYPASS_EN.
module tb_ram_mp;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main instance: defaults (OUT_REG=1, 2 write / 2 read ports)
    logic [1:0]             wr_en;
    logic [1:0][3:0]        wr_addr;
    logic [1:0][31:0]       wr_data;
    logic [1:0][3:0]        wr_be;
    logic [1:0]             rd_en;
    logic [1:0][3:0]        rd_addr;
    logic [1:0][31:0]       rd_data;
    logic [1:0]             rd_valid;
    logic                   ready;
    logic                   wr_coll;

    // combinational instance: OUT_REG=0, 4 write / 4 read ports
    logic [3:0]             c_wr_en;
    logic [3:0][3:0]        c_wr_addr;
    logic [3:0][31:0]       c_wr_data;
    logic [3:0][3:0]        c_wr_be;
    logic [3:0]             c_rd_en;
    logic [3:0][3:0]        c_rd_addr;
    logic [3:0][31:0]       c_rd_data;
    logic [3:0]             c_rd_valid;
    logic                   c_ready;
    logic                   c_coll;

    ram_mp dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_byte_en_i(wr_be),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .ready_o(ready), .wr_collision_o(wr_coll)
    );

    ram_mp #(.WR_PORTS(4), .RD_PORTS(4), .OUT_REG(1'b0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n),
        .wr_en_i(c_wr_en), .wr_addr_i(c_wr_addr), .wr_data_i(c_wr_data), .wr_byte_en_i(c_wr_be),
        .rd_en_i(c_rd_en), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data), .rd_valid_o(c_rd_valid),
        .ready_o(c_ready), .wr_collision_o(c_coll)
    );

`ifdef RAM_MP_BYPASS_EN
    localparam logic [31:0] RDW_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] RDW_EXP = 32'h00000000;
`endif

    // ---------------- scoreboard ----------------
    int n_total  = 0;
    int n_passed = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic c_idle();
        c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_wr_be = '0;
        c_rd_en = '0; c_rd_addr = '0;
    endtask

    // counts edges until ready_o rises; an expired budget reports 40
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (ready) break;
        end
        check({name, " ready edges"}, 32'(n), 32'd16);
        check({name, " c_ready"}, 32'(c_ready), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        w0_en;
        logic [3:0]  w0_addr;
        logic [31:0] w0_data;
        logic [3:0]  w0_be;
        logic        w1_en;
        logic [3:0]  w1_addr;
        logic [31:0] w1_data;
        logic [3:0]  w1_be;
        logic [3:0]  rd_addr;
        logic [31:0] exp_data;
        logic        exp_coll;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    function automatic vec_t mk(input string name,
                                input logic e0, input logic [3:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                                input logic e1, input logic [3:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                                input logic [3:0] ra, input logic [31:0] ed, input logic ec);
        vec_t v;
        v.name = name;
        v.w0_en = e0; v.w0_addr = a0; v.w0_data = d0; v.w0_be = b0;
        v.w1_en = e1; v.w1_addr = a1; v.w1_data = d1; v.w1_be = b1;
        v.rd_addr = ra; v.exp_data = ed; v.exp_coll = ec;
        return v;
    endfunction

    logic [31:0] c_val[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk("byte_en_0101", 1, 4'd3, 32'hAABBCCDD, 4'b0101, 0, 4'd0, 32'h0, 4'b0000, 4'd3, 32'h00BB00DD, 0);
        vecs[1] = mk("full_collide", 1, 4'd5, 32'h11111111, 4'b1111, 1, 4'd5, 32'h22222222, 4'b1111, 4'd5, 32'h11111111, 1);
        vecs[2] = mk("disjoint_merge", 1, 4'd6, 32'h11111111, 4'b0011, 1, 4'd6, 32'h22222222, 4'b1100, 4'd6, 32'h22221111, 0);
        vecs[3] = mk("p1_top_byte", 0, 4'd0, 32'h0, 4'b0000, 1, 4'd3, 32'h12345678, 4'b1000, 4'd3, 32'h12BB00DD, 0);
        vecs[4] = mk("two_addrs_a", 1, 4'd9, 32'hCAFEF00D, 4'b1111, 1, 4'd10, 32'h0BADBEEF, 4'b1111, 4'd9, 32'hCAFEF00D, 0);
        vecs[5] = mk("two_addrs_b", 0, 4'd0, 32'h0, 4'b0000, 0, 4'd0, 32'h0, 4'b0000, 4'd10, 32'h0BADBEEF, 0);
        vecs[6] = mk("partial_collide", 1, 4'd12, 32'hA0A0A0A0, 4'b0110, 1, 4'd12, 32'hB0B0B0B0, 4'b0011, 4'd12, 32'h00A0A0B0, 1);
        vecs[7] = mk("en_low_ignored", 0, 4'd15, 32'h0, 4'b1111, 1, 4'd15, 32'hFFFFFFFF, 4'b1111, 4'd15, 32'hFFFFFFFF, 0);
        vecs[8] = mk("be_zero_ignored", 1, 4'd15, 32'h0, 4'b0000, 0, 4'd0, 32'h0, 4'b0000, 4'd15, 32'hFFFFFFFF, 0);
        c_val[0] = 32'h01234567; c_val[1] = 32'h89ABCDEF; c_val[2] = 32'h5A5A5A5A; c_val[3] = 32'hC3C3C3C3;

        // ---- reset values, writes attempted during INIT ----
        idle();
        c_idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst ready", 32'(ready), 32'd0);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst rd_data0", rd_data[0], 32'd0);
        check("rst coll", 32'(wr_coll), 32'd0);
        wr_en = 2'b11; wr_addr[0] = 4'd4; wr_addr[1] = 4'd4;
        wr_data[0] = 32'hFFFFFFFF; wr_data[1] = 32'hFFFFFFFF; wr_be = '1;
        rd_en = 2'b11; rd_addr[0] = 4'd4; rd_addr[1] = 4'd4;
        c_rd_en = 4'hF;
        rst_n = 1'b1;
        repeat (8) tick();
        check("init ready low", 32'(ready), 32'd0);
        check("init rd_valid", 32'(rd_valid), 32'd0);
        check("init rd_data1", rd_data[1], 32'd0);
        check("init coll", 32'(wr_coll), 32'd0);
        check("init c_rd_valid", 32'(c_rd_valid), 32'd0);
        check("init c_rd_data0", c_rd_data[0], 32'd0);

        // ---- one-cycle reset pulse at clear counter 8 ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready("mid_init");
        idle();
        c_idle();

        // ---- every word reads back 0 ----
        for (int a = 0; a < 16; a++) begin
            rd_en = 2'b11;
            rd_addr[0] = 4'(a);
            rd_addr[1] = 4'(15 - a);
            tick();
            check($sformatf("clear rd0 a%0d", a), rd_data[0], 32'd0);
            check($sformatf("clear valid a%0d", a), 32'(rd_valid), 32'd3);
        end
        idle();

        // ---- table of write/read vectors ----
        for (int i = 0; i < NV; i++) begin
            wr_en   = {vecs[i].w1_en, vecs[i].w0_en};
            wr_addr[0] = vecs[i].w0_addr; wr_data[0] = vecs[i].w0_data; wr_be[0] = vecs[i].w0_be;
            wr_addr[1] = vecs[i].w1_addr; wr_data[1] = vecs[i].w1_data; wr_be[1] = vecs[i].w1_be;
            tick();
            idle();
            check({vecs[i].name, " coll"}, 32'(wr_coll), 32'(vecs[i].exp_coll));
            rd_en[0] = 1'b1;
            rd_addr[0] = vecs[i].rd_addr;
            exp_q.push_back(vecs[i].exp_data);
            tick();
            rd_en[0] = 1'b0;
            check({vecs[i].name, " valid"}, 32'(rd_valid[0]), 32'd1);
            check({vecs[i].name, " data"}, rd_data[0], exp_q.pop_front());
            check({vecs[i].name, " coll_gone"}, 32'(wr_coll), 32'd0);
        end

        // ---- read during write at addr 7 ----
        wr_en[0] = 1'b1; wr_addr[0] = 4'd7; wr_data[0] = 32'hDEADBEEF; wr_be[0] = 4'hF;
        rd_en[1] = 1'b1; rd_addr[1] = 4'd7;
        tick();
        idle();
        check("rdw same cycle", rd_data[1], RDW_EXP);
        rd_en[1] = 1'b1; rd_addr[1] = 4'd7;
        tick();
        check("rdw next read", rd_data[1], 32'hDEADBEEF);
        rd_en[1] = 1'b0;
        tick();
        check("hold valid low", 32'(rd_valid[1]), 32'd0);
        check("hold data", rd_data[1], 32'hDEADBEEF);

        // ---- combinational instance, 4 ports ----
        c_wr_en = 4'hF;
        for (int p = 0; p < 4; p++) begin
            c_wr_addr[p] = 4'(p); c_wr_data[p] = c_val[p]; c_wr_be[p] = 4'hF;
        end
        tick();
        c_idle();
        check("c no coll", 32'(c_coll), 32'd0);
        c_rd_en = 4'hF;
        for (int r = 0; r < 4; r++) c_rd_addr[r] = 4'(r);
        #1;
        for (int r = 0; r < 4; r++) check($sformatf("c rd%0d fwd", r), c_rd_data[r], c_val[r]);
        check("c valid all", 32'(c_rd_valid), 32'hF);
        for (int r = 0; r < 4; r++) c_rd_addr[r] = 4'(3 - r);
        #1;
        for (int r = 0; r < 4; r++) check($sformatf("c rd%0d rev", r), c_rd_data[r], c_val[3 - r]);
        c_rd_en = 4'b0101;
        #1;
        check("c valid follows en", 32'(c_rd_valid), 32'h5);
        c_idle();
        c_wr_en = 4'b1101;
        c_wr_addr[0] = 4'd9; c_wr_data[0] = 32'h0; c_wr_be[0] = 4'hF;
        c_wr_addr[2] = 4'd8; c_wr_data[2] = 32'h22222222; c_wr_be[2] = 4'b0011;
        c_wr_addr[3] = 4'd8; c_wr_data[3] = 32'h33333333; c_wr_be[3] = 4'hF;
        tick();
        c_idle();
        check("c coll p2p3", 32'(c_coll), 32'd1);
        c_rd_en[0] = 1'b1; c_rd_addr[0] = 4'd8;
        #1;
        check("c coll winner", c_rd_data[0], 32'h33332222);
        tick();
        check("c coll pulse", 32'(c_coll), 32'd0);
        c_idle();

        // ---- reset while READY with a valid read outstanding ----
        rd_en[0] = 1'b1; rd_addr[0] = 4'd7;
        tick();
        check("pre-rst data", rd_data[0], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("async ready", 32'(ready), 32'd0);
        check("async valid", 32'(rd_valid), 32'd0);
        check("async data", rd_data[0], 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        wait_ready("mid_ready");
        idle();
        rd_en = 2'b11; rd_addr[0] = 4'd7; rd_addr[1] = 4'd3;
        tick();
        idle();
        check("recleared a7", rd_data[0], 32'd0);
        check("recleared a3", rd_data[1], 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
